// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell reused per clock,
// LSB first, with a start/done handshake and registered results.
module full_subtractor_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  assign diff_o = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             cell_diff;
  logic             cell_bout;
  logic [WIDTH-1:0] d_next;

  full_subtractor_cell u_cell (
    .a_i   (a_sh_q[0]),
    .b_i   (b_sh_q[0]),
    .bin_i (borrow_q),
    .diff_o(cell_diff),
    .bout_o(cell_bout)
  );

  assign d_next = {cell_diff, d_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    d_sh_d   = d_sh_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        d_sh_d   = d_next;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = cell_bout;
        cnt_d    = cnt_q + CW'(1);
        // Results are captured on the edge entering DONE
        if (cnt_q == LAST) begin
          diff_d  = d_next;
          bout_d  = cell_bout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_sh_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      d_sh_q   <= d_sh_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed-vector bench for serial_subtractor_ctrl: WIDTH=8 table and corner
// sequences, plus an exhaustive back-to-back sweep on a WIDTH=4 instance.
module tb_serial_subtractor_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done4 = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t vt[6];

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // busy and done must never overlap
  always @(negedge clk) begin
    if (!rst) chk("busy_done_excl", {31'd0, busy8 & done8}, 32'd0);
  end

  // Scoreboard for the WIDTH=4 sweep
  always @(negedge clk) begin
    if (done4) begin
      n_done4++;
      if (exp_q.size() == 0) begin
        chk("w4_unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        chk("w4_result", {27'd0, bout4, diff4}, {27'd0, e});
      end
    end
  end

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb,
                     input logic tbin, input logic [7:0] ed,
                     input logic ebo, input string nm);
    int lat;
    int bcnt;
    @(negedge clk);
    a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!done8 && lat < 30) begin
      if (busy8) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, 9);
    chk({nm, "_busy_cycles"}, bcnt, 8);
    chk({nm, "_diff"}, {24'd0, diff8}, {24'd0, ed});
    chk({nm, "_bout"}, {31'd0, bout8}, {31'd0, ebo});
    @(negedge clk);
    chk({nm, "_done_pulse"}, {31'd0, done8}, 32'd0);
    chk({nm, "_diff_hold"}, {24'd0, diff8}, {24'd0, ed});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] r;
    int lat;
    int extra;

    vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vt[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vt[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vt[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vt[4] = '{8'h12, 8'h34, 1'b1, 8'hDD, 1'b1};
    vt[5] = '{8'hC8, 8'h64, 1'b1, 8'h63, 1'b0};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", {22'd0, busy8, done8, bout8, diff8},
          32'd0);
    end

    for (int i = 0; i < 6; i++) begin
      op8(vt[i].a, vt[i].b, vt[i].bin, vt[i].d, vt[i].bo,
          $sformatf("vec%0d", i));
    end

    // start pulse during RUN must be ignored
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("sib_done_seen", {31'd0, done8}, 32'd1);
    chk("sib_diff", {24'd0, diff8}, 32'h7F);
    chk("sib_bout", {31'd0, bout8}, 32'd0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy8 || done8) extra++;
    end
    chk("sib_no_second_op", extra, 0);

    // asynchronous reset during RUN cycle 4
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h0F; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rmid_busy_before", {31'd0, busy8}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rmid_outputs_zero", {22'd0, busy8, done8, bout8, diff8},
        32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy8 || done8) extra++;
    end
    chk("rmid_no_done", extra, 0);
    op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, "after_rst");

    // WIDTH=4 exhaustive sweep at the minimum issue interval
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      a4 = i[8:5]; b4 = i[4:1]; bin4 = i[0];
      r = {1'b0, a4} - {1'b0, b4} - {4'd0, bin4};
      exp_q.push_back(r);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("w4_done_count", n_done4, 512);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial multi-bit subtractor controller. It computes WIDTH-bit `A - B - bin` by sequencing the team's one-bit full-subtractor cell once per clock, LSB first. The borrow is held in a flip-flop between cycles, and the operands are held in shift registers. It sits between a requester using a start/done handshake and the single shared subtractor cell, trading latency for area.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range ≥ 2.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request pulse; sampled only in IDLE.
- `a`  input  WIDTH  minuend; sampled with an accepted `start`.
- `b`  input  WIDTH  subtrahend; sampled with an accepted `start`.
- `bin`  input  1  initial borrow-in; sampled with an accepted `start`.
- `busy`  output  1  high while a subtraction is in progress (RUN state).
- `done`  output  1  one-cycle pulse; result valid.
- `diff`  output  WIDTH  result `(a - b - bin) mod 2^WIDTH`.
- `bout`  output  1  final borrow-out; 1 iff `a < b + bin` (unsigned).

## Operation
- The block instantiates one combinational full-subtractor cell. Its inputs are `a_sh[0]`, `b_sh[0]` and `borrow_q`. Its outputs are cell `Diff` and cell `Bout`.
- Internal state:
  - `a_sh` and `b_sh`: WIDTH-bit shift registers.
  - `d_sh`: WIDTH-bit result shift register.
  - `borrow_q`: 1-bit borrow flip-flop.
  - `cnt`: bit counter, width `$clog2(WIDTH)`.
  - FSM state.
- FSM states: IDLE, RUN, DONE. Transitions:
  - IDLE, `start=1`:
    - Load `a_sh<=a`, `b_sh<=b`, `borrow_q<=bin`, `cnt<=0`.
    - Go to RUN.
  - IDLE, `start=0`: stay in IDLE. Hold `diff` and `bout`.
  - RUN, every cycle:
    - `d_sh <= {cell Diff, d_sh[WIDTH-1:1]}`.
    - `a_sh <= a_sh >> 1`, `b_sh <= b_sh >> 1`.
    - `borrow_q <= cell Bout`.
    - `cnt <= cnt + 1`.
  - RUN, `cnt == WIDTH-1`: perform the final bit update as above, then go to DONE.
  - DONE:
    - `done=1`.
    - `diff` shows `d_sh`; `bout` shows `borrow_q`.
    - Go to IDLE next cycle unconditionally.
- `diff` and `bout` are registered copies, updated only on DONE entry. They hold their value through IDLE until the next completion.
- `start` in RUN or DONE is ignored. It is not queued, and `a`, `b`, `bin` are not sampled.
- Arithmetic: unsigned, modulo 2^WIDTH. No sign interpretation. `bout` doubles as the "result negative" flag.
- Reset, asserted at any time including mid-RUN:
  - State goes to IDLE.
  - All shift registers, `borrow_q`, `cnt`, `diff` and `bout` go to 0.
  - `busy=0`, `done=0`.
  - The in-flight operation is discarded and no `done` is produced.

## Timing
- Reset values: `busy=0`, `done=0`, `diff=0`, `bout=0`.
- Edge numbering: `start` is accepted at edge E0 (state IDLE→RUN).
- `busy` is high from the cycle after E0 for exactly WIDTH cycles. It is a Moore output: `busy = (state==RUN)`.
- The last RUN update occurs at edge E(WIDTH). `done` is high for one cycle after E(WIDTH).
- Latency from accepting `start` to the `done` cycle is WIDTH+1 edges.
- Back-to-back throughput: the earliest next accepted `start` is the edge that leaves DONE. That edge is the IDLE edge after DONE, E(WIDTH+2). Minimum issue interval is WIDTH+2 cycles.
- `done` and `busy` are never high simultaneously.
- `diff` and `bout` are stable from the `done` cycle until the `done` cycle of the next operation.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then idle: assert `rst` for 2 cycles, then hold `start=0` for 20 cycles. Required: `busy=0`, `done=0`, `diff=0x00`, `bout=0` throughout.
- Basic subtraction (WIDTH=8): `a=0x5A`, `b=0x3C`, `bin=0`, one-cycle `start`. Required:
  - `busy` high for 8 cycles.
  - `done` pulse 9 edges after acceptance.
  - `diff=0x1E`, `bout=0`.
- Borrow chain: `a=0x00`, `b=0x01`, `bin=0` must give `diff=0xFF`, `bout=1`. Then `a=0x00`, `b=0x00`, `bin=1` must give `diff=0xFF`, `bout=1`. Then `a=0xFF`, `b=0xFF`, `bin=0` must give `diff=0x00`, `bout=0`.
- Start while busy:
  - Issue `a=0x80`, `b=0x01`, `bin=0`.
  - At cycle 3 of RUN, pulse `start` with `a=0x11`, `b=0x22`.
  - Required: a single `done` with `diff=0x7F`, `bout=0`. No second operation starts.
- Reset mid-operation:
  - Start `a=0xF0`, `b=0x0F`, `bin=0`.
  - Assert `rst` asynchronously, between edges, at RUN cycle 4.
  - Required: outputs go to 0 immediately and no `done` pulse appears.
  - A following operation `a=0x10`, `b=0x01`, `bin=0` yields `diff=0x0F`, `bout=0`.
- Exhaustive (WIDTH=4): all 512 combinations of `a`, `b`, `bin`, issued back-to-back at the minimum interval. Required: `diff` and `bout` match the reference model `{bout,diff} = a - b - bin` (5-bit two's complement) on every `done`.
